// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        DRAIN
    } sched_state_t;

    // div values below this behave as MIN_DIV so capture always finishes before the next step
    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned sel_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Step-period counter: counts 0..max(div,MIN_DIV) and flags the terminal count.
// Holds its value whenever advance is low; load latches div and clears the count.
module tick_divider
    import dac_sched_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             advance,
    output logic             terminal
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] limit;

    assign limit    = (div_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_q;
    assign terminal = (count_q == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            div_q   <= div;
            count_q <= '0;
        end else if (advance) begin
            count_q <= terminal ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Steps one selected DAC waveform generator at a programmable rate and hands each captured
// sample to the modulator over valid/ready. Optional macro: DAC_SCHED_OVERRUN_CNT_EN.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DIV_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [DIV_W-1:0]              div,
    input  logic [sel_width(NUM_SRC)-1:0] src_sel,
    input  logic [NUM_SRC*N-1:0]          src_data,
    output logic [NUM_SRC-1:0]            gen_ena,
    output logic [N-1:0]                  sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          busy,
`ifdef DAC_SCHED_OVERRUN_CNT_EN
    output logic [15:0]                   overrun_cnt,
`endif
    output logic                          overrun
);

    localparam int unsigned SelW = sel_width(NUM_SRC);

    sched_state_t        state_q, state_d;
    logic [SelW-1:0]     sel_q;
    logic [NUM_SRC-1:0]  gen_ena_q;
    logic                capture_pending_q;
    logic [N-1:0]        sample_data_q;
    logic                sample_valid_q;
    logic                overrun_q;

    logic start_ok;
    logic accept;
    logic blocked;
    logic terminal;
    logic advance;
    logic step;
    logic enter_stall;

    assign start_ok = (state_q == IDLE) && start && !stop;
    assign accept   = sample_valid_q && sample_ready;
    assign blocked  = sample_valid_q && !sample_ready;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_ok),
        .div      (div),
        .advance  (advance),
        .terminal (terminal)
    );

    always_comb begin
        state_d     = state_q;
        advance     = 1'b0;
        step        = 1'b0;
        enter_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (terminal && blocked) begin
                    // Freeze at terminal so the step is issued, not skipped, once unblocked
                    state_d     = STALL;
                    enter_stall = 1'b1;
                end else begin
                    advance = 1'b1;
                    step    = terminal;
                end
            end
            STALL: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (accept) begin
                    state_d = RUN;
                    advance = 1'b1;
                    step    = 1'b1;
                end
            end
            DRAIN: begin
                if (!capture_pending_q && !sample_valid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            sel_q             <= '0;
            gen_ena_q         <= '0;
            capture_pending_q <= 1'b0;
            sample_data_q     <= '0;
            sample_valid_q    <= 1'b0;
            overrun_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            gen_ena_q         <= step ? (NUM_SRC'(1) << sel_q) : '0;
            capture_pending_q <= |gen_ena_q;
            if (start_ok) begin
                sel_q <= src_sel;
            end
            if (capture_pending_q) begin
                sample_data_q  <= src_data[sel_q*N +: N];
                sample_valid_q <= 1'b1;
            end else if (accept) begin
                sample_valid_q <= 1'b0;
            end
            if (start_ok) begin
                overrun_q <= 1'b0;
            end else if (enter_stall) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef DAC_SCHED_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt_q <= '0;
        end else if (start_ok) begin
            overrun_cnt_q <= '0;
        end else if (enter_stall && (overrun_cnt_q != 16'hFFFF)) begin
            overrun_cnt_q <= overrun_cnt_q + 16'd1;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign gen_ena      = gen_ena_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomized and directed bench for dac_sample_scheduler against a cycle-level reference model.
module tb_dac_sample_scheduler;

    localparam int N       = 16;
    localparam int NUM_SRC = 4;
    localparam int DIV_W   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic [DIV_W-1:0]     div = '0;
    logic [1:0]           src_sel = '0;
    logic [NUM_SRC*N-1:0] src_data;
    logic [NUM_SRC-1:0]   gen_ena;
    logic [N-1:0]         sample_data;
    logic                 sample_valid;
    logic                 sample_ready = 1'b0;
    logic                 busy;
    logic                 overrun;
`ifdef DAC_SCHED_OVERRUN_CNT_EN
    logic [15:0]          overrun_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dac_sample_scheduler #(
        .N       (N),
        .NUM_SRC (NUM_SRC),
        .DIV_W   (DIV_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .div          (div),
        .src_sel      (src_sel),
        .src_data     (src_data),
        .gen_ena      (gen_ena),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
`ifdef DAC_SCHED_OVERRUN_CNT_EN
        .overrun_cnt  (overrun_cnt),
`endif
        .overrun      (overrun)
    );

    // Ramp generators: source k outputs k*4096 + number of steps taken; never reset by the DUT
    int gcnt [NUM_SRC];
    initial for (int k = 0; k < NUM_SRC; k++) gcnt[k] = 0;
    always @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) if (gen_ena[k]) gcnt[k] <= gcnt[k] + 1;
    end
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) src_data[k*N +: N] = 16'(k*4096 + gcnt[k]);
    end

    // Reference model: values the outputs must show after the next clock edge
    bit          m_busy, m_stall, m_drain, m_pend, m_valid, m_ovr;
    int          m_phase, m_per, m_sel, m_ena, m_ovr_cnt;
    logic [15:0] m_data;
    int          m_steps [NUM_SRC];

    task automatic model_reset();
        m_busy = 0; m_stall = 0; m_drain = 0; m_pend = 0; m_valid = 0; m_ovr = 0;
        m_phase = 0; m_per = 3; m_sel = 0; m_ena = -1; m_ovr_cnt = 0; m_data = '0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit rdy, input int dv,
                              input int sl);
        bit old_pend, old_valid, acc;
        int n_ena;
        old_pend  = m_pend;
        old_valid = m_valid;
        acc       = m_valid && rdy;
        n_ena     = -1;
        if (old_pend) begin
            m_valid = 1;
            m_data  = 16'(m_sel*4096 + m_steps[m_sel]);
        end else if (acc) begin
            m_valid = 0;
        end
        m_pend = (m_ena >= 0);
        if (!m_busy) begin
            if (st && !sp) begin
                m_busy = 1; m_per = ((dv < 2) ? 2 : dv) + 1; m_sel = sl;
                m_phase = 0; m_ovr = 0; m_ovr_cnt = 0;
            end
        end else if (m_drain) begin
            if (!old_pend && !old_valid) begin m_busy = 0; m_drain = 0; end
        end else if (sp) begin
            m_drain = 1; m_stall = 0;
        end else if (m_stall) begin
            if (acc) begin m_stall = 0; m_phase = 0; n_ena = m_sel; end
        end else if (m_phase == m_per - 1) begin
            if (old_valid && !rdy) begin
                m_stall = 1; m_ovr = 1;
                if (m_ovr_cnt < 65535) m_ovr_cnt++;
            end else begin
                m_phase = 0; n_ena = m_sel;
            end
        end else begin
            m_phase++;
        end
        if (n_ena >= 0) m_steps[n_ena]++;
        m_ena = n_ena;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gen_ena", 32'(gen_ena), (m_ena >= 0) ? (32'd1 << m_ena) : 32'd0);
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("sample_data", 32'(sample_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef DAC_SCHED_OVERRUN_CNT_EN
        chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr_cnt));
`endif
    endtask

    // One clock: check outputs after the previous edge, then drive inputs for the next edge
    task automatic cyc(input bit st, input bit sp, input bit rdy, input int dv, input int sl);
        @(negedge clk);
        check_all();
        start = st; stop = sp; sample_ready = rdy; div = DIV_W'(dv); src_sel = 2'(sl);
        model_step(st, sp, rdy, dv, sl);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, rdy, $urandom_range(0, 9), $urandom_range(0, 3));
    endtask

    task automatic stop_and_drain();
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 40 && m_busy; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("drain_to_idle", 32'(busy), 32'd0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 0; stop = 0; sample_ready = 0;
        #1;
        model_reset();
        chk("rst_gen_ena", 32'(gen_ena), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NUM_SRC; k++) m_steps[k] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Ramp on source 0, period 5, always ready
        cyc(1, 0, 1, 4, 0);
        idle_cycles(40, 1);
        stop_and_drain();

        // div=0 clamps to a 3-cycle period
        cyc(1, 0, 1, 0, 0);
        idle_cycles(30, 1);
        chk("no_overrun_div0", 32'(overrun), 32'd0);
        stop_and_drain();

        // Backpressure: stall, then release
        cyc(1, 0, 1, 4, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 4, 0);
        idle_cycles(14, 0);
        chk("stall_overrun", 32'(overrun), 32'd1);
        idle_cycles(12, 1);
        stop_and_drain();

        // Source 2 selected; select input changes to 1 mid-run
        cyc(1, 0, 1, 3, 2);
        for (int i = 0; i < 30; i++) cyc(0, 0, 1, 3, 1);
        stop_and_drain();

        // Stop one cycle after a step pulse with ready low; drain holds busy
        cyc(1, 0, 1, 4, 3);
        for (int i = 0; i < 20 && m_ena < 0; i++) cyc(0, 0, 1, 4, 3);
        cyc(0, 0, 0, 4, 3);
        cyc(0, 1, 0, 4, 3);
        idle_cycles(8, 0);
        chk("drain_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10 && m_busy; i++) cyc(0, 0, 1, 0, 0);
        idle_cycles(6, 1);
        chk("drain_done", 32'(busy), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 3),
                ($urandom_range(0, 99) < 65), $urandom_range(0, 6), $urandom_range(0, 3));
        end
        stop_and_drain();

        // Three forced stalls, then reset in STALL
        cyc(1, 0, 1, 3, 1);
        for (int r = 0; r < 3; r++) begin
            idle_cycles(12, 0);
            cyc(0, 0, 1, 3, 1);
        end
        idle_cycles(12, 0);
        async_reset();
        cyc(1, 0, 1, 3, 0);
        idle_cycles(25, 1);
        cyc(0, 0, 1, 3, 0);

        // Stall counting cleared by the next accepted start
        for (int r = 0; r < 3; r++) begin
            idle_cycles(12, 0);
            cyc(0, 0, 1, 3, 0);
        end
        stop_and_drain();
        cyc(1, 0, 1, 3, 2);
        idle_cycles(10, 1);
        chk("overrun_cleared", 32'(overrun), 32'd0);
        stop_and_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
